// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel-in / serial-out bundle between producer, serializer and detector.
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  modport master (output in_data, in_valid, input in_ready, dout, dout_valid, busy);
  modport slave  (input in_data, in_valid, output in_ready, dout, dout_valid, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first word serializer with one-word holding register.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  bit_serializer_if.slave  bus
);
`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_hold_full;
  logic             r_in_ready;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_busy;
`ifdef SER_PARITY_EN
  logic             r_par;
`endif
  logic             w_accept;
  logic             w_last;
  logic             w_load_evt;
  logic             w_load;
  logic             w_hold_full_nx;
  logic             w_shift_nx;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_word;
  always_comb begin
    w_accept       = bus.in_valid & r_in_ready;
    w_last         = (r_state == SHIFT) && (r_cnt == LAST);
    w_load_evt     = (r_state == IDLE) || w_last;
    w_load         = w_load_evt && (r_hold_full || w_accept);
    w_word         = r_hold_full ? r_hold : bus.in_data;
    // a held word is always consumed at a load event; a fresh word is consumed only if nothing was held
    w_hold_full_nx = (r_hold_full | w_accept) & ~w_load_evt;
    w_shift_nx     = w_load || ((r_state == SHIFT) && !w_last);
`ifdef SER_PARITY_EN
    w_next_bit     = (r_cnt == CW'(WIDTH - 1)) ? r_par : r_shift[WIDTH-1];
`else
    w_next_bit     = r_shift[WIDTH-1];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_hold_full  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_hold_full <= w_hold_full_nx;
      r_in_ready  <= ~w_hold_full_nx;
      r_busy      <= w_shift_nx | w_hold_full_nx;
      if (w_accept && !w_load_evt) r_hold <= bus.in_data;
      if (w_load) begin
        r_state      <= SHIFT;
        r_shift      <= {w_word[WIDTH-2:0], 1'b0};
        r_cnt        <= '0;
        r_dout       <= w_word[WIDTH-1];
        r_dout_valid <= 1'b1;
`ifdef SER_PARITY_EN
        r_par        <= ^w_word;
`endif
      end else if ((r_state == SHIFT) && !w_last) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + 1'b1;
        r_dout  <= w_next_bit;
      end else begin
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_dout       <= 1'b0;
        r_dout_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready   = r_in_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench; expected bits queued at accept, popped as dout_valid bits appear.
module tb_bit_serializer;
`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   run;
  int   max_run;
  int   det;
  logic [3:0] hist;
  logic q[$];
  bit_serializer_if #(.WIDTH(8)) bus();
  bit_serializer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    logic e;
    #1;
    if (bus.dout_valid) begin
      run++;
      if (run > max_run) max_run = run;
      hist = {hist[2:0], bus.dout};
      if (hist == 4'b1010) det++;
      tests++;
      if (q.size() == 0) begin
        failed++;
        $display("FAIL stray_bit: dout_valid=1 dout=%b with no bit expected at %0t", bus.dout, $time);
      end else begin
        e = q.pop_front();
        if (bus.dout !== e) begin
          failed++;
          $display("FAIL serial_bit: got %b expected %b at %0t", bus.dout, e, $time);
        end
      end
    end else begin
      run = 0;
      tests++;
      if (bus.dout !== 1'b0) begin
        failed++;
        $display("FAIL idle_dout: got %b expected 0 at %0t", bus.dout, $time);
      end
    end
  end
  task automatic push_exp(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q.push_back(w[i]);
`ifdef SER_PARITY_EN
    q.push_back(^w);
`endif
  endtask
  task automatic send(input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 100) begin
      failed++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    push_exp(w);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || bus.dout_valid || bus.busy) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    tests++;
    if (t >= 300) begin
      failed++;
      $display("FAIL drain_timeout: %0d bits still expected, required 0", q.size());
    end
  endtask
  task automatic clear_stats();
    max_run = 0;
    det = 0;
    hist = 4'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.dout_valid, bus.dout, bus.busy, bus.in_ready} !== 4'b0001) begin
      failed++;
      $display("FAIL reset_state: dv,dout,busy,rdy=%b required 0001", {bus.dout_valid, bus.dout, bus.busy, bus.in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
    end
  endtask
  task automatic test_single();
    clear_stats();
    send(8'hA5);
    tests++;
    if (bus.dout_valid !== 1'b1 || bus.busy !== 1'b1) begin
      failed++;
      $display("FAIL latency_first_bit: dv=%b busy=%b required 1 1", bus.dout_valid, bus.busy);
    end
    repeat (NB) @(posedge clk);
    #1;
    tests++;
    if (bus.dout_valid !== 1'b0) begin
      failed++;
      $display("FAIL word_end: dout_valid=%b required 0", bus.dout_valid);
    end
    drain();
    tests++;
    if (max_run != NB) begin
      failed++;
      $display("FAIL single_len: run=%0d required %0d", max_run, NB);
    end
  endtask
  task automatic test_back_to_back();
    clear_stats();
    send(8'h0A);
    send(8'h0A);
    drain();
    tests++;
    if (max_run != 2 * NB) begin
      failed++;
      $display("FAIL b2b_run: run=%0d required %0d", max_run, 2 * NB);
    end
    tests++;
    if (det != 2) begin
      failed++;
      $display("FAIL b2b_detect: pulses=%0d required 2", det);
    end
  endtask
  task automatic test_backpressure();
    int lows = 0;
    clear_stats();
    send(8'hFF);
    send(8'h00);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && lows < 100) begin
      lows++;
      @(negedge clk);
    end
    push_exp(8'h55);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tests++;
    if (lows != NB - 1) begin
      failed++;
      $display("FAIL ready_low_cycles: got %0d required %0d", lows, NB - 1);
    end
    drain();
    tests++;
    if (max_run != 3 * NB) begin
      failed++;
      $display("FAIL bp_run: run=%0d required %0d", max_run, 3 * NB);
    end
  endtask
  task automatic test_reset_mid();
    send(8'hC3);
    send(8'h3C);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    tests++;
    if ({bus.dout_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      failed++;
      $display("FAIL mid_reset: dv,rdy,busy=%b required 010", {bus.dout_valid, bus.in_ready, bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * NB + 2) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset_busy: got %b required 0", bus.busy);
    end
  endtask
  task automatic test_reset_accept();
    @(negedge clk);
    rst = 1'b1;
    bus.in_data = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (NB + 4) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.in_ready} !== 2'b01) begin
      failed++;
      $display("FAIL reset_accept: busy,rdy=%b required 01", {bus.busy, bus.in_ready});
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 10)) @(posedge clk);
    end
    drain();
  endtask
  initial begin
    tests = 0;
    failed = 0;
    run = 0;
    clear_stats();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_reset_accept();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, meaning bits per parallel word (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_data  input  WIDTH  parallel word from the upstream producer.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle; driven directly from a register.
REQ-007 dout  output  1  serial bit stream; feeds the din port of the downstream sequence-detector FSM.
REQ-008 dout_valid  output  1  dout carries a payload bit this cycle.
REQ-009 busy  output  1  high while a word is shifting or the holding register is full.

Function
REQ-010 The block SHALL accept a word on every rising clk edge where in_valid and in_ready are both high; at all other edges it SHALL ignore in_data.
REQ-011 The block SHALL contain a shift register, a bit counter, a one-word holding register, and a two-state FSM: IDLE and SHIFT.
REQ-012 in_ready SHALL equal NOT hold_full: it is high whenever the holding register is empty, including during SHIFT.
REQ-013 Load event: occurs in IDLE, or in SHIFT on the edge that emits the last bit of a word. At a load event the shift register SHALL load the holding register if full; otherwise it SHALL load the word accepted at that edge, bypassing the holding register.
REQ-014 An accepted word not consumed by a load event SHALL be written to the holding register, setting hold_full.
REQ-015 A load from the holding register SHALL clear hold_full unless a new word is accepted at the same edge; in that case the new word replaces the old one and hold_full stays set.
REQ-016 Latency: a word accepted in IDLE at edge N SHALL appear MSB-first with dout_valid=1 during cycles N+1 .. N+WIDTH.
REQ-017 Back-to-back operation: if a word is available at the last-bit edge, its MSB SHALL follow the previous LSB in the very next cycle, with no dout_valid gap.
REQ-018 FSM transitions:
- IDLE->SHIFT on a load event.
- SHIFT->SHIFT on the last bit if a word is available to load.
- SHIFT->IDLE on the last bit if no word is available.
REQ-019 In IDLE, dout SHALL be 0 and dout_valid SHALL be 0.
REQ-020 dout, dout_valid and busy SHALL be registered outputs, with no combinational path from in_valid or in_data.
REQ-021 The bit counter SHALL count 0..WIDTH-1 (WIDTH with parity enabled) and SHALL wrap to 0 on every load event.
REQ-022 If the holding register is full and in_valid is high, in_ready SHALL be 0 and the word SHALL stay pending at the producer without loss.

Reset
REQ-023 While rst is high at a clk edge, the FSM SHALL go to IDLE and all of the following SHALL clear to 0: shift register, bit counter, hold_full, dout, dout_valid, busy.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-025 An accept attempted at an edge where rst is high SHALL be ignored.
REQ-026 Reset during SHIFT SHALL discard both the in-flight word and the held word; no partial-word bits SHALL appear after reset.

Configuration
REQ-027 Macro SER_PARITY_EN:
- Defined: after each word's LSB, the block SHALL emit one even-parity bit (XOR of the word) with dout_valid=1, so each word occupies WIDTH+1 cycles, and the load event moves to the parity-bit edge.
- Undefined: no parity logic and exactly WIDTH cycles per word.

Verification
REQ-028 WIDTH=8, in IDLE, accept 8'hA5 at edge N -> dout = 1,0,1,0,0,1,0,1 in cycles N+1..N+8; dout_valid=0 in cycle N+9.
REQ-029 Accept 8'h0A then 8'h0A with in_valid held high -> 16 contiguous dout_valid cycles carrying 0000101000001010; downstream detector pulses twice.
REQ-030 Accept 8'hFF, then 8'h00, then present 8'h55 with in_valid high -> in_ready=0 until the 8'hFF LSB edge; output order FF, 00, 55 with no gaps or loss.
REQ-031 Assert rst for one cycle after the 3rd bit of 8'hC3 -> dout_valid=0 the next cycle, in_ready=1, busy=0, and no remaining C3 bits appear.
REQ-032 SER_PARITY_EN defined, accept 8'h07 -> dout = 0,0,0,0,0,1,1,1 then 1, over 9 dout_valid cycles.
REQ-033 in_valid pulsed while rst is high -> no word emitted after reset.
